// File: rtl/riscv_zero_decode_pipe_if.sv
// riscv_zero_decode_pipe_if: fetch, writeback and execute-side
// signals of the decode stage, grouped with master/slave views.
interface riscv_zero_decode_pipe_if #(
  parameter int XLEN     = 64,
  parameter int ALU_OP_W = 4
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         inst_data;
  logic [XLEN-1:0]     pc_in;
  logic                reg_wenable;
  logic [4:0]          reg_waddr;
  logic [XLEN-1:0]     reg_wdata;
  logic                out_valid;
  logic                out_ready;
  logic [6:0]          opcode;
  logic [XLEN-1:0]     immediate;
  logic [4:0]          reg_dest;
  logic [XLEN-1:0]     reg1_out;
  logic [XLEN-1:0]     reg2_out;
  logic [XLEN-1:0]     pc_out;
  logic                writeback_enable;
  logic [1:0]          writeback_source;
  logic                mem_wenable;
  logic                jump;
  logic                branch;
  logic                ALU_A_mux;
  logic                ALU_B_mux;
  logic [ALU_OP_W-1:0] ALU_OP;
  logic                illegal;

  modport master (
    output flush, in_valid, inst_data, pc_in,
    output reg_wenable, reg_waddr, reg_wdata,
    output out_ready,
    input  in_ready, out_valid, opcode, immediate,
    input  reg_dest, reg1_out, reg2_out, pc_out,
    input  writeback_enable, writeback_source,
    input  mem_wenable, jump, branch,
    input  ALU_A_mux, ALU_B_mux, ALU_OP, illegal
  );

  modport slave (
    input  flush, in_valid, inst_data, pc_in,
    input  reg_wenable, reg_waddr, reg_wdata,
    input  out_ready,
    output in_ready, out_valid, opcode, immediate,
    output reg_dest, reg1_out, reg2_out, pc_out,
    output writeback_enable, writeback_source,
    output mem_wenable, jump, branch,
    output ALU_A_mux, ALU_B_mux, ALU_OP, illegal
  );
endinterface

// File: rtl/riscv_zero_decode_pipe.sv
// riscv_zero_decode_pipe: RV32I/RV64I decode stage with register
// file, writeback bypass and a single-entry output register.
module riscv_zero_decode_pipe #(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32,
  parameter int ALU_OP_W = 4
) (
  input logic clk,
  input logic reset_n,
  riscv_zero_decode_pipe_if.slave bus
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [5:0] NR = 6'(NUM_REGS);
  localparam bit RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32  = 7'b0111011;

  typedef struct packed {
    logic [6:0]          opcode;
    logic [XLEN-1:0]     imm;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [XLEN-1:0]     r1;
    logic [XLEN-1:0]     r2;
    logic [XLEN-1:0]     pc;
    logic                wb_en;
    logic [1:0]          wb_src;
    logic                mem_wen;
    logic                jump;
    logic                branch;
    logic                a_sel;
    logic                b_sel;
    logic [ALU_OP_W-1:0] alu_op;
    logic                illegal;
  } id_ex_t;

  logic [31:0]     inst;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [31:0]     imm_i;
  logic [31:0]     imm_s;
  logic [31:0]     imm_b;
  logic [31:0]     imm_u;
  logic [31:0]     imm_j;
  logic signed [31:0] imm32;
  logic [XLEN-1:0] imm_x;
  logic            sh_ok_l;
  logic            sh_ok_r;

  logic            d_wb;
  logic [1:0]      d_src;
  logic            d_mw;
  logic            d_jmp;
  logic            d_br;
  logic            d_a;
  logic            d_b;
  logic            d_lui;
  logic            alt;
  logic [2:0]      fn3;
  logic            br_op;
  logic            bad;
  logic            use_rd;
  logic            use_rs1;
  logic            use_rs2;
  logic            rng_bad;
  logic            d_ill;
  logic [ALU_OP_W-1:0] d_alu;

  logic [XLEN-1:0] rf [NUM_REGS];
  logic            wr_ok;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  id_ex_t          d;
  id_ex_t          q;
  logic            vld;
  logic            accept;
  logic            stall;

  assign inst = bus.inst_data;
  assign opc  = inst[6:0];
  assign rd   = inst[11:7];
  assign f3   = inst[14:12];
  assign rs1  = inst[19:15];
  assign rs2  = inst[24:20];
  assign f7   = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'd0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};
  assign imm_x = XLEN'(imm32);

  // RV64 shift amounts are 6 bits, so only inst[31:26] is funct
  assign sh_ok_l = RV64 ? (f7[6:1] == 6'd0) : (f7 == 7'd0);
  assign sh_ok_r = RV64 ?
    (f7[6:1] == 6'd0 || f7[6:1] == 6'b010000) :
    (f7 == 7'd0 || f7 == 7'h20);

  // opcode/funct decode into control fields and format immediate
  always_comb begin
    d_wb    = 1'b0;
    d_src   = 2'd0;
    d_mw    = 1'b0;
    d_jmp   = 1'b0;
    d_br    = 1'b0;
    d_a     = 1'b0;
    d_b     = 1'b0;
    d_lui   = 1'b0;
    alt     = 1'b0;
    fn3     = 3'd0;
    br_op   = 1'b0;
    bad     = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm32   = '0;
    unique case (1'b1)
      (opc == OPC_OP): begin
        d_wb = 1'b1; alt = f7[5]; fn3 = f3;
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        bad = !(f7 == 7'h00 ||
                (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      (opc == OPC_OP32): begin
        d_wb = 1'b1; alt = f7[5]; fn3 = f3;
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        bad = !RV64 ||
              !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5) ||
              !(f7 == 7'h00 ||
                (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      (opc == OPC_IMM): begin
        d_wb = 1'b1; d_b = 1'b1; imm32 = imm_i; fn3 = f3;
        alt = (f3 == 3'd5) & f7[5];
        use_rd = 1'b1; use_rs1 = 1'b1;
        if (f3 == 3'd1) bad = !sh_ok_l;
        else if (f3 == 3'd5) bad = !sh_ok_r;
      end
      (opc == OPC_IMM32): begin
        d_wb = 1'b1; d_b = 1'b1; imm32 = imm_i; fn3 = f3;
        alt = (f3 == 3'd5) & f7[5];
        use_rd = 1'b1; use_rs1 = 1'b1;
        if (f3 == 3'd1) bad = (f7 != 7'h00);
        else if (f3 == 3'd5) bad = !(f7 == 7'h00 || f7 == 7'h20);
        else bad = (f3 != 3'd0);
        if (!RV64) bad = 1'b1;
      end
      (opc == OPC_LOAD): begin
        d_wb = 1'b1; d_src = 2'd1; d_b = 1'b1; imm32 = imm_i;
        use_rd = 1'b1; use_rs1 = 1'b1;
        bad = (f3 == 3'd7) || (!RV64 && (f3 == 3'd3 || f3 == 3'd6));
      end
      (opc == OPC_STORE): begin
        d_mw = 1'b1; d_b = 1'b1; imm32 = imm_s;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        bad = (f3[2] == 1'b1) || (!RV64 && f3 == 3'd3);
      end
      (opc == OPC_BR): begin
        d_br = 1'b1; br_op = 1'b1; imm32 = imm_b;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        bad = (f3 == 3'd2 || f3 == 3'd3);
      end
      (opc == OPC_JAL): begin
        d_jmp = 1'b1; d_a = 1'b1; d_b = 1'b1; imm32 = imm_j;
        d_wb = 1'b1; d_src = 2'd2; use_rd = 1'b1;
      end
      (opc == OPC_JALR): begin
        d_jmp = 1'b1; d_b = 1'b1; imm32 = imm_i;
        d_wb = 1'b1; d_src = 2'd2;
        use_rd = 1'b1; use_rs1 = 1'b1;
        bad = (f3 != 3'd0);
      end
      (opc == OPC_AUIPC): begin
        d_a = 1'b1; d_b = 1'b1; imm32 = imm_u;
        d_wb = 1'b1; use_rd = 1'b1;
      end
      (opc == OPC_LUI): begin
        d_lui = 1'b1; d_b = 1'b1; imm32 = imm_u;
        d_wb = 1'b1; use_rd = 1'b1;
      end
      default: bad = 1'b1;
    endcase
  end

  // RVE builds reject register fields above the implemented count
  assign rng_bad = (use_rd  && {1'b0, rd}  >= NR) ||
                   (use_rs1 && {1'b0, rs1} >= NR) ||
                   (use_rs2 && {1'b0, rs2} >= NR);
  assign d_ill = bad | rng_bad;
  assign d_alu = br_op ? ALU_OP_W'(4'b1000) : ALU_OP_W'({alt, fn3});

  assign wr_ok = bus.reg_wenable && (bus.reg_waddr != 5'd0) &&
                 ({1'b0, bus.reg_waddr} < NR);

  // register file; x0 is never written
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wr_ok) begin
      rf[bus.reg_waddr[AW-1:0]] <= bus.reg_wdata;
    end
  end

  // rs1 read with same-cycle writeback bypass
  always_comb begin
    rs1_val = '0;
    if (rs1 != 5'd0 && {1'b0, rs1} < NR) begin
      rs1_val = (wr_ok && bus.reg_waddr == rs1) ?
                bus.reg_wdata : rf[rs1[AW-1:0]];
    end
  end

  // rs2 read with same-cycle writeback bypass
  always_comb begin
    rs2_val = '0;
    if (rs2 != 5'd0 && {1'b0, rs2} < NR) begin
      rs2_val = (wr_ok && bus.reg_waddr == rs2) ?
                bus.reg_wdata : rf[rs2[AW-1:0]];
    end
  end

  // assemble the beat that loads into the stage register
  always_comb begin
    d         = '0;
    d.opcode  = opc;
    d.imm     = imm_x;
    d.rd      = rd;
    d.rs1     = d_lui ? 5'd0 : rs1;
    d.rs2     = rs2;
    d.r1      = d_lui ? '0 : rs1_val;
    d.r2      = rs2_val;
    d.pc      = bus.pc_in;
    d.wb_en   = d_wb & ~d_ill;
    d.wb_src  = d_src;
    d.mem_wen = d_mw & ~d_ill;
    d.jump    = d_jmp & ~d_ill;
    d.branch  = d_br & ~d_ill;
    d.a_sel   = d_a;
    d.b_sel   = d_b;
    d.alu_op  = d_alu;
    d.illegal = d_ill;
  end

  assign bus.in_ready = reset_n & ~bus.flush & (~vld | bus.out_ready);
  assign accept = bus.in_valid & bus.in_ready;
  assign stall  = vld & ~bus.out_ready;

  // stage register: load, drain, flush, refresh operands while held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (bus.flush) begin
      vld <= 1'b0;
    end else if (accept) begin
      q   <= d;
      vld <= 1'b1;
    end else if (bus.out_ready) begin
      vld <= 1'b0;
    end else if (stall && wr_ok) begin
      if (bus.reg_waddr == q.rs1) q.r1 <= bus.reg_wdata;
      if (bus.reg_waddr == q.rs2) q.r2 <= bus.reg_wdata;
    end
  end

  assign bus.out_valid        = vld;
  assign bus.opcode           = q.opcode;
  assign bus.immediate        = q.imm;
  assign bus.reg_dest         = q.rd;
  assign bus.reg1_out         = q.r1;
  assign bus.reg2_out         = q.r2;
  assign bus.pc_out           = q.pc;
  assign bus.writeback_enable = q.wb_en;
  assign bus.writeback_source = q.wb_src;
  assign bus.mem_wenable      = q.mem_wen;
  assign bus.jump             = q.jump;
  assign bus.branch           = q.branch;
  assign bus.ALU_A_mux        = q.a_sel;
  assign bus.ALU_B_mux        = q.b_sel;
  assign bus.ALU_OP           = q.alu_op;
  assign bus.illegal          = q.illegal;

endmodule

// File: tb/tb_riscv_zero_decode_pipe.sv
// tb_riscv_zero_decode_pipe: directed and random checks of the
// decode stage against an ISA-level reference model.
module tb_riscv_zero_decode_pipe;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  riscv_zero_decode_pipe_if #(.XLEN(64), .ALU_OP_W(4)) b64 ();
  riscv_zero_decode_pipe_if #(.XLEN(32), .ALU_OP_W(4)) b32 ();

  riscv_zero_decode_pipe #(.XLEN(64), .NUM_REGS(32), .ALU_OP_W(4))
    u64 (.clk(clk), .reset_n(reset_n), .bus(b64));
  riscv_zero_decode_pipe #(.XLEN(32), .NUM_REGS(32), .ALU_OP_W(4))
    u32 (.clk(clk), .reset_n(reset_n), .bus(b32));

  typedef struct packed {
    logic [6:0]  opc;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] pc;
    logic        wb;
    logic [1:0]  src;
    logic        mw;
    logic        jmp;
    logic        br;
    logic        a;
    logic        b;
    logic [3:0]  alu;
    logic        ill;
  } exp_t;

  logic [63:0] mregs [32];
  exp_t        ex;
  bit          ev;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ISA-level decode: fields, immediates by arithmetic, legality by sets
  function automatic exp_t dec(input logic [31:0] w, input bit rv64);
    exp_t e;
    longint sw;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    sw = longint'($signed(w));
    f3 = w[14:12];
    f7 = w[31:25];
    e = '0;
    e.opc = w[6:0];
    e.rd = w[11:7];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    ok = 1'b1;
    case (w[6:0])
      7'h33: begin
        e.wb = 1; e.alu = {w[30], f3};
        ok = (f7 == 0) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
      end
      7'h3B: begin
        e.wb = 1; e.alu = {w[30], f3};
        ok = rv64 && f3 inside {3'd0, 3'd1, 3'd5} &&
             (f7 == 0 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}));
      end
      7'h13: begin
        e.imm = sw >>> 20; e.b = 1; e.wb = 1;
        e.alu = {(f3 == 3'd5) && w[30], f3};
        if (f3 == 3'd1) ok = rv64 ? (w[31:26] == 0) : (f7 == 0);
        if (f3 == 3'd5)
          ok = rv64 ? (w[31:26] inside {6'd0, 6'd16}) :
                      (f7 inside {7'd0, 7'd32});
      end
      7'h1B: begin
        e.imm = sw >>> 20; e.b = 1; e.wb = 1;
        e.alu = {(f3 == 3'd5) && w[30], f3};
        case (f3)
          3'd0: ok = 1;
          3'd1: ok = (f7 == 0);
          3'd5: ok = f7 inside {7'd0, 7'd32};
          default: ok = 0;
        endcase
        ok = ok && rv64;
      end
      7'h03: begin
        e.imm = sw >>> 20; e.b = 1; e.wb = 1; e.src = 1;
        ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} ||
             (rv64 && f3 inside {3'd3, 3'd6});
      end
      7'h23: begin
        e.imm = ((sw >>> 25) <<< 5) | longint'(w[11:7]);
        e.b = 1; e.mw = 1;
        ok = f3 inside {3'd0, 3'd1, 3'd2} || (rv64 && f3 == 3'd3);
      end
      7'h63: begin
        e.imm = ((sw >>> 31) <<< 12) | (longint'(w[7]) << 11) |
                (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
        e.br = 1; e.alu = 4'b1000;
        ok = !(f3 inside {3'd2, 3'd3});
      end
      7'h6F: begin
        e.imm = ((sw >>> 31) <<< 20) | (longint'(w[19:12]) << 12) |
                (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
        e.jmp = 1; e.a = 1; e.b = 1; e.wb = 1; e.src = 2;
      end
      7'h67: begin
        e.imm = sw >>> 20; e.jmp = 1; e.b = 1; e.wb = 1; e.src = 2;
        ok = (f3 == 0);
      end
      7'h17: begin
        e.imm = (sw >>> 12) <<< 12; e.a = 1; e.b = 1; e.wb = 1;
      end
      7'h37: begin
        e.imm = (sw >>> 12) <<< 12; e.b = 1; e.wb = 1; e.rs1 = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      e.ill = 1; e.wb = 0; e.mw = 0; e.jmp = 0; e.br = 0;
    end
    return e;
  endfunction

  function automatic logic [63:0] opnd(input logic [4:0] idx,
      input bit we, input logic [4:0] wa, input logic [63:0] wd);
    if (idx == 0) return 64'd0;
    if (we && wa == idx) return wd;
    return mregs[idx];
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h3B;  2: w[6:0] = 7'h13;
      3: w[6:0] = 7'h1B;  4: w[6:0] = 7'h03;  5: w[6:0] = 7'h23;
      6: w[6:0] = 7'h63;  7: w[6:0] = 7'h6F;  8: w[6:0] = 7'h67;
      9: w[6:0] = 7'h17; 10: w[6:0] = 7'h37;
      default: ;
    endcase
    if (w[6:0] inside {7'h33, 7'h3B, 7'h13, 7'h1B} &&
        $urandom_range(0, 3) != 0)
      w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic check_out();
    chk("out_valid", b64.out_valid, ev);
    if (ev) begin
      chk("opcode", b64.opcode, ex.opc);
      chk("immediate", b64.immediate, ex.imm);
      chk("reg_dest", b64.reg_dest, ex.rd);
      chk("reg1_out", b64.reg1_out, ex.r1);
      chk("reg2_out", b64.reg2_out, ex.r2);
      chk("pc_out", b64.pc_out, ex.pc);
      chk("wb_en", b64.writeback_enable, ex.wb);
      chk("wb_src", b64.writeback_source, ex.src);
      chk("mem_wen", b64.mem_wenable, ex.mw);
      chk("jump", b64.jump, ex.jmp);
      chk("branch", b64.branch, ex.br);
      chk("a_mux", b64.ALU_A_mux, ex.a);
      chk("b_mux", b64.ALU_B_mux, ex.b);
      chk("alu_op", b64.ALU_OP, ex.alu);
      chk("illegal", b64.illegal, ex.ill);
    end
  endtask

  task automatic step(input bit iv, input logic [31:0] w,
      input logic [63:0] pc, input bit ordy, input bit fl,
      input bit we, input logic [4:0] wa, input logic [63:0] wd);
    bit rdy;
    @(negedge clk);
    b64.in_valid = iv;
    b64.inst_data = w;
    b64.pc_in = pc;
    b64.out_ready = ordy;
    b64.flush = fl;
    b64.reg_wenable = we;
    b64.reg_waddr = wa;
    b64.reg_wdata = wd;
    #1;
    rdy = !fl && (!ev || ordy);
    chk("in_ready", b64.in_ready, rdy);
    if (fl) ev = 0;
    else if (iv && rdy) begin
      ex = dec(w, 1'b1);
      ex.pc = pc;
      ex.r1 = (w[6:0] == 7'h37) ? 64'd0 : opnd(w[19:15], we, wa, wd);
      ex.r2 = opnd(w[24:20], we, wa, wd);
      ev = 1;
    end else if (ordy) ev = 0;
    else if (ev && we && wa != 0) begin
      if (wa == ex.rs1) ex.r1 = wd;
      if (wa == ex.rs2) ex.r2 = wd;
    end
    if (we && wa != 0) mregs[wa] = wd;
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    exp_t e32;
    reset_n = 1'b0;
    ev = 0;
    ex = '0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    b64.in_valid = 0; b64.inst_data = '0; b64.pc_in = '0;
    b64.out_ready = 1; b64.flush = 0; b64.reg_wenable = 0;
    b64.reg_waddr = '0; b64.reg_wdata = '0;
    b32.in_valid = 0; b32.inst_data = '0; b32.pc_in = '0;
    b32.out_ready = 1; b32.flush = 0; b32.reg_wenable = 0;
    b32.reg_waddr = '0; b32.reg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", b64.out_valid, 1'b0);
    chk("rst_in_ready", b64.in_ready, 1'b0);
    chk("rst_immediate", b64.immediate, 64'd0);
    chk("rst_opcode", b64.opcode, 7'd0);
    chk("rst_alu_op", b64.ALU_OP, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // XLEN=32 build rejects addiw
    @(negedge clk);
    b32.in_valid = 1;
    b32.inst_data = 32'h0010809B;
    b32.pc_in = 32'h0000_0100;
    @(posedge clk);
    #1;
    e32 = dec(32'h0010809B, 1'b0);
    chk("x32_out_valid", b32.out_valid, 1'b1);
    chk("x32_illegal", b32.illegal, 1'b1);
    chk("x32_wb_en", b32.writeback_enable, 1'b0);
    chk("x32_model_ill", b32.illegal, e32.ill);
    chk("x32_imm", b32.immediate, e32.imm[31:0]);
    @(negedge clk);
    b32.in_valid = 0;

    // addi x1,x0,5
    step(1, 32'h00500093, 64'h1000, 1, 0, 0, 5'd0, 64'd0);
    chk("addi_imm", b64.immediate, 64'd5);
    chk("addi_rd", b64.reg_dest, 5'd1);
    chk("addi_bmux", b64.ALU_B_mux, 1'b1);
    chk("addi_alu", b64.ALU_OP, 4'd0);

    // add x2,x1,x1 with x1 written the same cycle
    step(1, 32'h00108133, 64'h1004, 1, 0, 1, 5'd1, 64'h1234);
    chk("byp_r1", b64.reg1_out, 64'h1234);
    chk("byp_r2", b64.reg2_out, 64'h1234);

    // two stall cycles; second carries writeback to x1
    step(1, 32'h00500093, 64'h1008, 0, 0, 0, 5'd0, 64'd0);
    chk("stall_pc", b64.pc_out, 64'h1004);
    step(1, 32'h00500093, 64'h1008, 0, 0, 1, 5'd1, 64'h55);
    chk("refresh_r1", b64.reg1_out, 64'h55);
    step(0, 32'h0, 64'h0, 1, 0, 0, 5'd0, 64'd0);

    // beq x1,x2,-4
    step(1, 32'hFE208EE3, 64'h2000, 1, 0, 0, 5'd0, 64'd0);
    chk("beq_branch", b64.branch, 1'b1);
    chk("beq_imm", b64.immediate, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_alu", b64.ALU_OP, 4'b1000);
    chk("beq_bmux", b64.ALU_B_mux, 1'b0);

    // flush a held beat and the incoming one, then read x0
    step(1, 32'h00A00293, 64'h2004, 0, 0, 0, 5'd0, 64'd0);
    step(1, 32'h00108133, 64'h2008, 0, 1, 1, 5'd0, 64'd7);
    chk("flush_valid", b64.out_valid, 1'b0);
    step(1, 32'h000001B3, 64'h200C, 1, 0, 1, 5'd0, 64'd7);
    chk("x0_r1", b64.reg1_out, 64'd0);

    // addiw is legal on RV64
    step(1, 32'h0010809B, 64'h2010, 1, 0, 0, 5'd0, 64'd0);
    chk("addiw64_ill", b64.illegal, 1'b0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] w;
      logic [63:0] pc;
      w = gen();
      pc = {$urandom, $urandom} & ~64'h3;
      step($urandom_range(0, 3) != 0, w, pc,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
           {$urandom, $urandom});
    end

    // asynchronous reset in the middle of a stall
    step(1, 32'h00500093, 64'h3000, 0, 0, 0, 5'd0, 64'd0);
    step(0, 32'h0, 64'h0, 0, 0, 0, 5'd0, 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", b64.out_valid, 1'b0);
    chk("arst_in_ready", b64.in_ready, 1'b0);
    chk("arst_imm", b64.immediate, 64'd0);
    chk("arst_r1", b64.reg1_out, 64'd0);
    chk("arst_pc", b64.pc_out, 64'd0);
    chk("arst_wb", b64.writeback_enable, 1'b0);
    ev = 0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 32'h00108133, 64'h4000, 1, 0, 0, 5'd0, 64'd0);
    chk("post_rst_r1", b64.reg1_out, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
